// File: rtl/led_pulse_pkg.sv
// Shared constants for the LED pulse stretcher: FSM state encoding and the 1 ms tick period.
package led_pulse_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ON   = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  // 50 MHz master clock -> 50000 cycles per 1 ms tick
  localparam int TICK_PERIOD_1MS = 50000;

endpackage

// File: rtl/led_pulse_stretcher_if.sv
// Event-in / LED-status bundle between chronometer control (master) and the stretcher (slave).
interface led_pulse_stretcher_if #(
    parameter int PEND_W = 3
);
    logic              event_in;
    logic              led;
    logic              busy;
    logic [PEND_W-1:0] pending;
    logic              overflow;

    modport master (output event_in, input led, busy, pending, overflow);
    modport slave  (input event_in, output led, busy, pending, overflow);
endinterface

// File: rtl/ms_tick_prescaler.sv
// Divides clk_ms down to a one-cycle tick every TICK_PERIOD cycles; clear restarts the count.
module ms_tick_prescaler
    import led_pulse_pkg::*;
#(
    parameter int TICK_PERIOD = TICK_PERIOD_1MS
) (
    input  logic clk_ms,
    input  logic reset,
    input  logic clear,
    output logic tick
);
    localparam int            W    = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
    localparam logic [W-1:0]  LAST = W'(TICK_PERIOD - 1);

    logic [W-1:0] count;

    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk_ms) begin
        if (reset || clear)
            count <= '0;
        else if (count == LAST)
            count <= '0;
        else
            count <= count + 1'b1;
    end

    assign tick = (count == LAST);
endmodule

// File: rtl/led_pulse_stretcher.sv
// Turns rising edges on event_in into ON_TICKS ms LED flashes with an OFF_TICKS ms dark gap, queueing extras.
// Optional LED_PULSE_RETRIGGER_EN: an edge during ON restarts the ON timer instead of queueing.
module led_pulse_stretcher
    import led_pulse_pkg::*;
#(
    parameter int TICK_PERIOD = TICK_PERIOD_1MS,
    parameter int ON_TICKS    = 100,
    parameter int OFF_TICKS   = 100,
    parameter int PEND_W      = 3
) (
    input  logic                 clk_ms,
    input  logic                 reset,
    led_pulse_stretcher_if.slave bus
);
    localparam int MAX_TICKS = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int CNT_W     = $clog2(MAX_TICKS + 1);
    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_TICKS - 1);
    localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_TICKS - 1);

    logic [1:0]        state, state_next;
    logic [CNT_W-1:0]  tick_cnt, tick_cnt_next;
    logic [PEND_W-1:0] pending_q;
    logic              event_d, ev_edge;
    logic              led_q, busy_q, overflow_q;
    logic              tick, clear, start, retrig, deq, enq;

    ms_tick_prescaler #(.TICK_PERIOD(TICK_PERIOD)) u_prescaler (
        .clk_ms (clk_ms),
        .reset  (reset),
        .clear  (clear),
        .tick   (tick)
    );

    assign ev_edge = bus.event_in & ~event_d;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next    = state;
        tick_cnt_next = tick_cnt;
        start         = 1'b0;
        retrig        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ev_edge || (pending_q != '0)) begin
                    state_next    = ST_ON;
                    tick_cnt_next = '0;
                    start         = 1'b1;
                end
            end
            ST_ON: begin
`ifdef LED_PULSE_RETRIGGER_EN
                retrig = ev_edge;
`endif
                if (retrig) begin
                    tick_cnt_next = '0;
                end else if (tick) begin
                    if (tick_cnt == ON_LAST) begin
                        state_next    = ST_GAP;
                        tick_cnt_next = '0;
                    end else begin
                        tick_cnt_next = tick_cnt + 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (tick) begin
                    if (tick_cnt == OFF_LAST) begin
                        state_next    = ST_IDLE;
                        tick_cnt_next = '0;
                    end else begin
                        tick_cnt_next = tick_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_next    = ST_IDLE;
                tick_cnt_next = '0;
            end
        endcase
    end

    // Prescaler restarts on every state change so each phase spans whole ticks.
    assign clear = (state == ST_IDLE) || (state_next != state) || retrig;
    assign deq   = start && (pending_q != '0);
    assign enq   = ev_edge && !(start && (pending_q == '0)) && !retrig;

    always_ff @(posedge clk_ms) begin
        if (reset) begin
            state      <= ST_IDLE;
            tick_cnt   <= '0;
            pending_q  <= '0;
            event_d    <= 1'b0;
            led_q      <= 1'b0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            event_d  <= bus.event_in;
            state    <= state_next;
            tick_cnt <= tick_cnt_next;
            led_q    <= (state_next == ST_ON);
            busy_q   <= (state_next != ST_IDLE);
            case ({enq, deq})
                2'b10: begin
                    if (pending_q == '1)
                        overflow_q <= 1'b1;
                    else
                        pending_q <= pending_q + 1'b1;
                end
                2'b01:   pending_q <= pending_q - 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.led      = led_q;
    assign bus.busy     = busy_q;
    assign bus.pending  = pending_q;
    assign bus.overflow = overflow_q;
endmodule
